eth_tx_frame_arbiter: RTL and testbench

//  Frame-level round-robin arbiter sharing one MAC TX AXI-stream input (eth_mac_1g_rgmii_fifo tx_axis_*)

---
 rtl/eth_tx_frame_arbiter_pkg.sv | 12 +
 rtl/eth_rr_pick.sv | 29 ++
 rtl/eth_tx_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_frame_arbiter_pkg.sv
// Shared types for the MAC TX frame arbiter.
// Arbiter FSM state encoding, reused by the RX-side dispatcher.
package eth_tx_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin select.
// First requester strictly after the one-hot last owner, wrapping.
module eth_rr_pick #(
  parameter int PORTS = 2
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [PORTS-1:0] last_i,
  output logic [PORTS-1:0] gnt_o,
  output logic             valid_o
);

  logic [PORTS-1:0] hi_mask;
  logic [PORTS-1:0] hi_req;
  logic [PORTS-1:0] pool;

  // hi_mask marks ports above the last owner
  always_comb begin
    hi_mask = '0;
    for (int i = 1; i < PORTS; i++) begin
      hi_mask[i] = hi_mask[i-1] | last_i[i-1];
    end
  end

  assign hi_req  = req_i & hi_mask;
  assign pool    = (|hi_req) ? hi_req : req_i;
  assign gnt_o   = pool & (~pool + 1'b1);
  assign valid_o = |req_i;

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the MAC TX stream.
// Grant held per frame; a stalled source is cut off with a bad beat.
module eth_tx_frame_arbiter #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic [PORTS-1:0]            grant,
  output logic                        busy,
  output logic [PORTS*CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]        abort_cnt
);

  import eth_tx_frame_arbiter_pkg::*;

  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [SW-1:0] STALL_MAX = SW'(TO_M1);
  localparam logic [PORTS-1:0] LAST_RST =
    {1'b1, {(PORTS-1){1'b0}}};

  arb_state_e state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [PORTS-1:0] last_q, last_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] cnt_q [PORTS];
  logic [CNT_WIDTH-1:0] abort_q;

  logic [PORTS-1:0] frame_inc;
  logic abort_inc;

  logic [PORTS-1:0] pick_gnt;
  logic pick_valid;

  logic [DATA_WIDTH-1:0] sel_data;
  logic sel_valid;
  logic sel_last;
  logic sel_user;

  eth_rr_pick #(
    .PORTS(PORTS)
  ) u_pick (
    .req_i  (s_axis_tvalid),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_valid)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    stall_d       = stall_q;
    frame_inc     = '0;
    abort_inc     = 1'b0;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          last_d  = pick_gnt;
          stall_d = '0;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        m_axis_tdata  = sel_data;
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = sel_last;
        m_axis_tuser  = sel_user;
        s_axis_tready = grant_q & {PORTS{m_axis_tready}};
        if (sel_valid) begin
          stall_d = '0;
          if (m_axis_tready && sel_last) begin
            frame_inc = grant_q;
            grant_d   = '0;
            state_d   = ST_IDLE;
          end
        end else if (TIMEOUT != 0) begin
          // Only a silent source counts; MAC backpressure never does
          if (stall_q == STALL_MAX) begin
            state_d = ST_ABORT;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      ST_ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          abort_inc = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        s_axis_tready = grant_q;
        if (sel_valid && sel_last) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      stall_q <= '0;
      abort_q <= '0;
      for (int i = 0; i < PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      if (abort_inc) begin
        abort_q <= abort_q + 1'b1;
      end
      for (int i = 0; i < PORTS; i++) begin
        if (frame_inc[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_cnt
    assign frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

  assign abort_cnt = abort_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Self-checking bench for eth_tx_frame_arbiter.
// Frame-level model: per-port source queues and a round-robin plan.
module tb_eth_tx_frame_arbiter;

  localparam int P  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 4;

  typedef struct {
    logic [9:0] b;
    int         p;
    bit         ab;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [P*DW-1:0] s_tdata;
  logic [P-1:0] s_tvalid;
  logic [P-1:0] s_tready;
  logic [P-1:0] s_tlast;
  logic [P-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic m_tvalid;
  logic m_tready;
  logic m_tlast;
  logic m_tuser;
  logic [P-1:0] grant;
  logic busy;
  logic [P*CW-1:0] frame_cnt;
  logic [CW-1:0] abort_cnt;

  always #4 clk = ~clk;

  eth_tx_frame_arbiter #(
    .PORTS(P),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser),
    .grant(grant),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .abort_cnt(abort_cnt)
  );

  logic [9:0] srcq [P][$];
  exp_t expq [$];
  int m_last;
  int fcnt [P];
  int acnt;
  bit stall [P];
  int stall_at [P];
  int sent [P];
  int stall_cyc;
  bit abort_seen;
  int gap_state;
  int mode;
  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] b, input int p, input bit ab);
    exp_t e;
    e.b = b;
    e.p = p;
    e.ab = ab;
    expq.push_back(e);
  endtask

  task automatic add_frame(input int p, input int len, input bit bad,
                           input bit seq);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      d = seq ? 8'(p * 64 + i) : 8'($urandom);
      srcq[p].push_back({bad && (i == len - 1), i == len - 1, d});
    end
  endtask

  // Expected output order: whole frames, next pending port after last
  task automatic plan();
    logic [9:0] tq [P][$];
    logic [9:0] b;
    int pick;
    for (int p = 0; p < P; p++) tq[p] = srcq[p];
    do begin
      pick = -1;
      for (int k = 1; k <= P; k++) begin
        if (pick < 0 && tq[(m_last + k) % P].size() > 0)
          pick = (m_last + k) % P;
      end
      if (pick >= 0) begin
        do begin
          b = tq[pick].pop_front();
          push_exp(b, pick, 1'b0);
        end while (!b[8]);
        m_last = pick;
      end
    end while (pick >= 0);
  endtask

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      srcq[p].delete();
      fcnt[p] = 0;
      stall[p] = 1'b0;
      stall_at[p] = -1;
      sent[p] = 0;
    end
    expq.delete();
    m_last = P - 1;
    acnt = 0;
    gap_state = 0;
    abort_seen = 1'b0;
    stall_cyc = 0;
  endtask

  task automatic tick();
    logic [9:0] ob;
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      if (srcq[p].size() > 0 && !stall[p]) begin
        s_tvalid[p] = 1'b1;
        s_tdata[p*DW +: DW] = srcq[p][0][7:0];
        s_tlast[p] = srcq[p][0][8];
        s_tuser[p] = srcq[p][0][9];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tdata[p*DW +: DW] = 8'($urandom);
        s_tlast[p] = 1'($urandom);
        s_tuser[p] = 1'($urandom);
      end
    end
    m_tready = (mode == 0) ? 1'($urandom) : (mode == 1);
    #1;
    if (gap_state == 2) begin
      chk("decide_busy", 32'(busy), 32'd1);
      gap_state = 0;
    end
    if (gap_state == 1) begin
      chk("gap_idle", 32'({busy, grant, m_tvalid}), 32'd0);
      gap_state = (|s_tvalid) ? 2 : 0;
    end
    for (int p = 0; p < P; p++) begin
      if (stall[p] && !abort_seen) begin
        if (!m_tvalid) stall_cyc++;
        else begin
          chk("stall_len", 32'(stall_cyc), 32'(TO));
          abort_seen = 1'b1;
          stall[p] = 1'b0;
        end
      end
    end
    if (m_tvalid && m_tready) begin
      ob = {m_tuser, m_tlast, m_tdata};
      n_chk++;
      assert (expq.size() > 0) else begin
        n_fail++;
        $error("FAIL extra_beat: observed 0x%0h expected no beat", ob);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("beat", 32'(ob), 32'(e.b));
        chk("grant", 32'(grant), 32'd1 << e.p);
        if (e.b[8]) begin
          if (e.ab) acnt = (acnt + 1) % (1 << CW);
          else begin
            fcnt[e.p] = (fcnt[e.p] + 1) % (1 << CW);
            gap_state = 1;
          end
        end
      end
    end
    for (int p = 0; p < P; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        srcq[p].delete(0);
        sent[p]++;
        if (sent[p] == stall_at[p]) begin
          stall[p] = 1'b1;
          stall_at[p] = -1;
        end
      end
    end
  endtask

  task automatic run(input int budget);
    int cyc;
    bit work;
    cyc = 0;
    do begin
      work = expq.size() > 0;
      for (int p = 0; p < P; p++) if (srcq[p].size() > 0) work = 1'b1;
      if (work) begin
        tick();
        cyc++;
      end
    end while (work && cyc < budget);
    n_chk++;
    assert (!work) else begin
      n_fail++;
      $error("FAIL run_budget: observed %0d cycles busy expected done", cyc);
      expq.delete();
      for (int p = 0; p < P; p++) srcq[p].delete();
    end
    tick();
    tick();
  endtask

  task automatic check_cnts(input string tag);
    for (int p = 0; p < P; p++) begin
      chk($sformatf("%s_frame_cnt%0d", tag, p),
          32'(frame_cnt[p*CW +: CW]), 32'(fcnt[p]));
    end
    chk({tag, "_abort_cnt"}, 32'(abort_cnt), 32'(acnt));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_m_ctl"}, 32'({m_tvalid, m_tlast, m_tuser}), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_abort_cnt"}, 32'(abort_cnt), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    mode = 1;
    rst = 1'b1;
    s_tvalid = '1;
    s_tdata = '0;
    s_tlast = '0;
    s_tuser = '0;
    m_tready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    reset_checks("por");
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = '0;

    // Two ports, 64-byte frames, alternating owners
    mode = 1;
    add_frame(0, 64, 1'b0, 1'b1);
    add_frame(1, 64, 1'b0, 1'b1);
    add_frame(0, 64, 1'b0, 1'b1);
    add_frame(1, 64, 1'b0, 1'b1);
    plan();
    run(2000);
    check_cnts("t1");

    // P0 stalls after 10 beats: abort beat, drain, then P1
    mode = 0;
    for (int p = 0; p < P; p++) sent[p] = 0;
    abort_seen = 1'b0;
    stall_cyc = 0;
    add_frame(0, 20, 1'b0, 1'b0);
    add_frame(1, 8, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) push_exp(srcq[0][i], 0, 1'b0);
    push_exp(10'h300, 0, 1'b1);
    for (int i = 0; i < srcq[1].size(); i++) push_exp(srcq[1][i], 1, 1'b0);
    m_last = 1;
    stall_at[0] = 10;
    run(2000);
    chk("t3_abort_seen", 32'(abort_seen), 32'd1);
    check_cnts("t3");

    // Long MAC backpressure mid-frame must not abort
    mode = 0;
    add_frame(0, 100, 1'b0, 1'b0);
    plan();
    repeat (20) tick();
    mode = 2;
    repeat (2000) tick();
    chk("t2_busy_hold", 32'(busy), 32'd1);
    mode = 0;
    run(2000);
    check_cnts("t2");

    // Bad-frame flag passes through as a normal frame
    add_frame(1, 12, 1'b1, 1'b0);
    plan();
    run(1000);
    check_cnts("t4");

    // Reset in the middle of a P1 frame
    mode = 1;
    add_frame(1, 40, 1'b0, 1'b0);
    plan();
    repeat (10) tick();
    chk("t5_midframe", 32'(grant), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    reset_checks("t5");
    model_reset();
    s_tvalid = '0;
    rst = 1'b0;
    add_frame(0, 6, 1'b0, 1'b0);
    add_frame(1, 6, 1'b0, 1'b0);
    plan();
    run(1000);
    check_cnts("t5b");

    // Last owner P1, requests on P1 and P3
    mode = 0;
    add_frame(1, 5, 1'b0, 1'b0);
    add_frame(3, 5, 1'b0, 1'b0);
    plan();
    run(1000);
    check_cnts("t6");

    // Sixteen frames on P2 wrap its counter to zero
    for (int i = 0; i < 16; i++) add_frame(2, $urandom_range(1, 4), 1'b0, 1'b0);
    plan();
    run(2000);
    check_cnts("wrap");

    // Random mixes across all ports
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 15; i++) begin
        add_frame($urandom_range(0, P - 1), $urandom_range(1, 20),
                  $urandom_range(0, 7) == 0, 1'b0);
      end
      plan();
      run(5000);
      check_cnts($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
